// File: rtl/bike_pkg.sv
// Shared constants, state encoding and helpers for the lightbike motion sequencer.
package bike_pkg;

  localparam int STEP   = 2;
  localparam int SPRITE = 30;
  localparam int H_RES  = 640;
  localparam int V_RES  = 480;

  localparam logic signed [10:0] STEP_S = 11'(STEP);
  localparam logic signed [10:0] X_MAX  = 11'(H_RES - SPRITE);
  localparam logic signed [10:0] Y_MAX  = 11'(V_RES - SPRITE);
  localparam logic [10:0]        SPRITE_W = 11'(SPRITE);

  localparam logic [2:0] UP      = 3'd0;
  localparam logic [2:0] LEFT    = 3'd1;
  localparam logic [2:0] DOWN    = 3'd2;
  localparam logic [2:0] RIGHT   = 3'd3;
  localparam logic [2:0] CRASHED = 3'd5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    MOVE  = 3'd2,
    CHECK = 3'd3,
    OVER  = 3'd4
  } state_t;

  // Opposite orients differ only in bit 1; a crashed bike has no reverse.
  function automatic logic is_reversal(logic [2:0] cur, logic [1:0] req);
    return !cur[2] && ((cur[1:0] ^ req) == 2'b10);
  endfunction

  function automatic logic [18:0] pix_addr(logic [9:0] x, logic [9:0] y);
    return ({9'b0, y} << 9) + ({9'b0, y} << 7) + {9'b0, x};
  endfunction

endpackage

// File: rtl/bike_motion_ctrl_if.sv
// Control and sprite-drive signals between the game logic and the motion sequencer.
interface bike_motion_ctrl_if;

  logic        start;
  logic        frame_tick;
  logic        dir_valid0;
  logic [1:0]  dir0;
  logic        dir_valid1;
  logic [1:0]  dir1;
  logic [18:0] startaddr0;
  logic [2:0]  orient0;
  logic [18:0] startaddr1;
  logic [2:0]  orient1;
  logic        running;
  logic        crash0;
  logic        crash1;
  logic        done;

  modport master (
    output start, frame_tick, dir_valid0, dir0, dir_valid1, dir1,
    input  startaddr0, orient0, startaddr1, orient1, running, crash0, crash1, done
  );

  modport slave (
    input  start, frame_tick, dir_valid0, dir0, dir_valid1, dir1,
    output startaddr0, orient0, startaddr1, orient1, running, crash0, crash1, done
  );

endinterface

// File: rtl/bike_axis_step.sv
// One bike: pending steering request, orient, position step with wall check,
// and the registered sprite start address.
module bike_axis_step
  import bike_pkg::*;
#(
  parameter logic [9:0] X0  = 10'd100,
  parameter logic [9:0] Y0  = 10'd225,
  parameter logic [2:0] OR0 = 3'd3
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        init,
  input  logic        move,
  input  logic        collide,
  input  logic        dir_valid,
  input  logic [1:0]  dir,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic [2:0]  orient,
  output logic        crash,
  output logic [18:0] startaddr
);

  logic              pend_valid;
  logic [1:0]        pend_dir;
  logic [2:0]        eff_orient;
  logic signed [10:0] nx;
  logic signed [10:0] ny;
  logic              out_of_bounds;

  // Next position is formed in 11-bit signed so stepping below zero is visible.
  always_comb begin
    eff_orient = pend_valid ? {1'b0, pend_dir} : orient;
    nx = signed'({1'b0, x});
    ny = signed'({1'b0, y});
    case (eff_orient)
      UP:      ny = ny - STEP_S;
      LEFT:    nx = nx - STEP_S;
      DOWN:    ny = ny + STEP_S;
      RIGHT:   nx = nx + STEP_S;
      default: begin end
    endcase
    out_of_bounds = (nx < 0) || (nx > X_MAX) || (ny < 0) || (ny > Y_MAX);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      x          <= X0;
      y          <= Y0;
      orient     <= OR0;
      crash      <= 1'b0;
      pend_valid <= 1'b0;
      pend_dir   <= 2'd0;
      startaddr  <= pix_addr(X0, Y0);
    end else begin
      startaddr <= pix_addr(x, y);
      if (init) begin
        x          <= X0;
        y          <= Y0;
        orient     <= OR0;
        crash      <= 1'b0;
        pend_valid <= 1'b0;
      end else begin
        if (move) begin
          if (out_of_bounds) begin
            orient <= CRASHED;
            crash  <= 1'b1;
          end else begin
            x      <= nx[9:0];
            y      <= ny[9:0];
            orient <= eff_orient;
          end
        end else if (collide) begin
          orient <= CRASHED;
          crash  <= 1'b1;
        end
        // A fresh request wins over the post-move clear.
        if (dir_valid && !is_reversal(orient, dir)) begin
          pend_valid <= 1'b1;
          pend_dir   <= dir;
        end else if (move) begin
          pend_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/bike_motion_ctrl.sv
// Per-frame sequencer for both lightbikes: frame FSM, head-on check, and the
// two per-bike step units driving the sprite box checkers.
module bike_motion_ctrl
  import bike_pkg::*;
(
  input logic               clock,
  input logic               resetn,
  bike_motion_ctrl_if.slave bus
);

  state_t      state;
  logic        init;
  logic        move;
  logic        close;
  logic        collide;
  logic [9:0]  x0, y0, x1, y1;
  logic [10:0] dx, dy;

  assign init = bus.start && ((state == IDLE) || (state == OVER));
  assign move = (state == MOVE);

  always_comb begin
    dx = (x0 > x1) ? {1'b0, x0 - x1} : {1'b0, x1 - x0};
    dy = (y0 > y1) ? {1'b0, y0 - y1} : {1'b0, y1 - y0};
    close   = (dx < SPRITE_W) && (dy < SPRITE_W);
    collide = (state == CHECK) && close;
  end

  bike_axis_step #(.X0(10'd100), .Y0(10'd225), .OR0(RIGHT)) u_bike0 (
    .clock     (clock),
    .resetn    (resetn),
    .init      (init),
    .move      (move),
    .collide   (collide),
    .dir_valid (bus.dir_valid0),
    .dir       (bus.dir0),
    .x         (x0),
    .y         (y0),
    .orient    (bus.orient0),
    .crash     (bus.crash0),
    .startaddr (bus.startaddr0)
  );

  bike_axis_step #(.X0(10'd510), .Y0(10'd225), .OR0(LEFT)) u_bike1 (
    .clock     (clock),
    .resetn    (resetn),
    .init      (init),
    .move      (move),
    .collide   (collide),
    .dir_valid (bus.dir_valid1),
    .dir       (bus.dir1),
    .x         (x1),
    .y         (y1),
    .orient    (bus.orient1),
    .crash     (bus.crash1),
    .startaddr (bus.startaddr1)
  );

  // running/done are registered alongside the state so they never glitch.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      bus.running <= 1'b0;
      bus.done    <= 1'b0;
    end else begin
      case (state)
        IDLE, OVER: begin
          if (bus.start) begin
            state       <= RUN;
            bus.running <= 1'b1;
            bus.done    <= 1'b0;
          end
        end
        RUN: begin
          if (bus.frame_tick) state <= MOVE;
        end
        MOVE: state <= CHECK;
        CHECK: begin
          if (bus.crash0 || bus.crash1 || close) begin
            state       <= OVER;
            bus.running <= 1'b0;
            bus.done    <= 1'b1;
          end else begin
            state <= RUN;
          end
        end
        default: begin
          state       <= IDLE;
          bus.running <= 1'b0;
          bus.done    <= 1'b0;
        end
      endcase
    end
  end

endmodule
